// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU op encodings, register zero, datapath width
// and the execute-stage FSM states.
package pipeline_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_XOR = 3'd5,
        ALU_NOR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU; the MUL encoding yields zero here because
// multiplication lives in the execute stage.
module alu #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    import pipeline_pkg::*;

    logic lt;

    assign lt = $signed(a) < $signed(b);

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, lt};
            ALU_XOR: y = a ^ b;
            ALU_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, destination select and the EX/MEM register.
// Defining EX_MUL_EN adds the multi-cycle MUL with its stall FSM.
module ex_stage #(
    parameter int MUL_LATENCY = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        Rs_a,
    input  logic [4:0]        Rt_a,
    input  logic [4:0]        Rd_a,
    input  logic [DATA_W-1:0] Rs_data,
    input  logic [DATA_W-1:0] Rt_data,
    input  logic [DATA_W-1:0] immediate,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUOp,
    input  logic              RegDst,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic              wb_RegWrite,
    input  logic [4:0]        wb_Wr_a,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [4:0]        Wr_a_out,
    output logic              MemWrite_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic              stall
);
    import pipeline_pkg::*;

    if (MUL_LATENCY < 1 || MUL_LATENCY > 16) begin : g_bad_latency
        $error("MUL_LATENCY must be within 1..16");
    end

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_y;
    logic [4:0]        wr_a;
    logic              exm_ok;
    logic              wb_ok;

    logic [DATA_W-1:0] n_res;
    logic [DATA_W-1:0] n_st;
    logic [4:0]        n_wra;
    logic              n_mw;
    logic              n_mtr;
    logic              n_rw;

    // A load in EX/MEM has no data yet, so it never forwards from there.
    assign exm_ok = RegWrite_out & ~MemToReg_out & (Wr_a_out != REG_ZERO);
    assign wb_ok  = wb_RegWrite & (wb_Wr_a != REG_ZERO);

    always_comb begin
        fwd_a = Rs_data;
        if (exm_ok && Wr_a_out == Rs_a)
            fwd_a = ALU_result_out;
        else if (wb_ok && wb_Wr_a == Rs_a)
            fwd_a = wb_data;
    end

    always_comb begin
        fwd_b = Rt_data;
        if (exm_ok && Wr_a_out == Rt_a)
            fwd_b = ALU_result_out;
        else if (wb_ok && wb_Wr_a == Rt_a)
            fwd_b = wb_data;
    end

    assign op_b = ALUSrc ? immediate : fwd_b;
    assign wr_a = RegDst ? Rd_a : Rt_a;

    alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op(ALUOp),
        .a (fwd_a),
        .b (op_b),
        .y (alu_y)
    );

`ifdef EX_MUL_EN
    localparam int CNT_W = 5;

    ex_state_e         state;
    ex_state_e         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_st;
    logic [4:0]        mul_wra;
    logic              mul_mw;
    logic              mul_mtr;
    logic              mul_rw;
    logic              is_mul;
    logic              mul_start;
    logic [DATA_W-1:0] m_a;
    logic [DATA_W-1:0] m_b;
    logic [DATA_W-1:0] prod;

    assign is_mul    = alu_op_e'(ALUOp) == ALU_MUL;
    assign mul_start = (state == IDLE) & is_mul & (MUL_LATENCY > 1);

    // One multiplier serves both the latched BUSY operands and MUL_LATENCY==1.
    assign m_a  = (state == BUSY) ? mul_a : fwd_a;
    assign m_b  = (state == BUSY) ? mul_b : op_b;
    assign prod = m_a * m_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (mul_start)
                cnt <= CNT_W'(MUL_LATENCY - 1);
            else if (state == BUSY)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mul_start) begin
            mul_a   <= fwd_a;
            mul_b   <= op_b;
            mul_st  <= fwd_b;
            mul_wra <= wr_a;
            mul_mw  <= MemWrite;
            mul_mtr <= MemToReg;
            mul_rw  <= RegWrite;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (mul_start) state_nxt = BUSY;
            BUSY:    if (cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        n_res = is_mul ? prod : alu_y;
        n_st  = fwd_b;
        n_wra = wr_a;
        n_mw  = MemWrite;
        n_mtr = MemToReg;
        n_rw  = RegWrite;
        if (mul_start || (state == BUSY && cnt > CNT_W'(1))) begin
            stall = ~reset;
            n_res = '0;
            n_st  = '0;
            n_wra = REG_ZERO;
            n_mw  = 1'b0;
            n_mtr = 1'b0;
            n_rw  = 1'b0;
        end else if (state == BUSY) begin
            n_res = prod;
            n_st  = mul_st;
            n_wra = mul_wra;
            n_mw  = mul_mw;
            n_mtr = mul_mtr;
            n_rw  = mul_rw;
        end
    end
`else
    assign stall = 1'b0;

    always_comb begin
        n_res = alu_y;
        n_st  = fwd_b;
        n_wra = wr_a;
        n_mw  = MemWrite;
        n_mtr = MemToReg;
        n_rw  = RegWrite;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ALU_result_out <= '0;
            store_data_out <= '0;
            Wr_a_out       <= REG_ZERO;
            MemWrite_out   <= 1'b0;
            MemToReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
        end else begin
            ALU_result_out <= n_res;
            store_data_out <= n_st;
            Wr_a_out       <= n_wra;
            MemWrite_out   <= n_mw;
            MemToReg_out   <= n_mtr;
            RegWrite_out   <= n_rw;
        end
    end

endmodule
